// File: rtl/calibration_sequencer.sv
// Sequences one calibration capture pass per LED address bit (MSB first),
// handshaking with the calibration FSM and guarding each pass with a timeout.
module calibration_sequencer #(
    parameter int LED_ADDRESS_WIDTH = 10,
    parameter int SETTLE_CYCLES     = 1024,
    parameter int TIMEOUT_CYCLES    = 50000000
) (
    input  logic                                  clk_pixel,
    input  logic                                  rst_n,
    input  logic                                  start_in,
    input  logic                                  abort_in,
    input  logic [2:0]                            cal_state_in,
    output logic [((LED_ADDRESS_WIDTH > 1) ? $clog2(LED_ADDRESS_WIDTH) : 1)-1:0] pattern_bit_out,
    output logic                                  pattern_update_out,
    output logic                                  increment_id_out,
    output logic                                  should_overwrite_out,
    output logic                                  busy_out,
    output logic                                  done_out,
    output logic                                  error_out
);

    localparam int BIT_W = (LED_ADDRESS_WIDTH > 1) ? $clog2(LED_ADDRESS_WIDTH) : 1;
    localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int SET_W = $clog2(SETTLE_CYCLES + 1);
    localparam logic [BIT_W-1:0] BIT_TOP  = BIT_W'(LED_ADDRESS_WIDTH - 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TMR_W-1:0] TMR_MAX  = TMR_W'(TIMEOUT_CYCLES);
    localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETTLE_CYCLES - 1);
    localparam logic [SET_W-1:0] SET_MAX  = SET_W'(SETTLE_CYCLES);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_LOAD      = 3'd1,
        S_KICK      = 3'd2,
        S_WAIT_BUSY = 3'd3,
        S_WAIT_IDLE = 3'd4,
        S_SETTLE    = 3'd5,
        S_DONE      = 3'd6,
        S_ERROR     = 3'd7
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic               r_start_d;
    logic               r_armed;
    logic [TMR_W-1:0]   r_timer;
    logic [SET_W-1:0]   r_settle;
    logic [BIT_W-1:0]   r_bit;
    logic [BIT_W-1:0]   r_pbit;
    logic               r_pupd, r_inc, r_ow, r_busy, r_done, r_err;

    logic [TMR_W-1:0]   w_timer_n;
    logic [SET_W-1:0]   w_settle_n;
    logic [BIT_W-1:0]   w_bit_n, w_pbit_n;
    logic               w_pupd_n, w_inc_n, w_ow_n, w_busy_n, w_done_n, w_err_n;
    logic               w_start_edge, w_timeout, w_settle_done;

    // r_armed masks the first cycle after reset so a start held through reset is not an edge
    assign w_start_edge  = start_in & ~r_start_d & r_armed;
    assign w_timeout     = (r_timer == TMR_LAST);
    assign w_settle_done = (r_settle == SET_LAST);

    // State register
    always_ff @(posedge clk_pixel or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode: abort beats timeout beats the normal flow
    always_comb begin
        w_next = r_state;
        if (abort_in) begin
            w_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:      w_next = w_start_edge ? S_LOAD : S_IDLE;
                S_LOAD:      w_next = S_KICK;
                S_KICK:      w_next = S_WAIT_BUSY;
                S_WAIT_BUSY: begin
                    if (w_timeout)                 w_next = S_ERROR;
                    else if (cal_state_in != 3'd0) w_next = S_WAIT_IDLE;
                    else                           w_next = S_WAIT_BUSY;
                end
                S_WAIT_IDLE: begin
                    if (w_timeout)                 w_next = S_ERROR;
                    else if (cal_state_in == 3'd0) w_next = S_SETTLE;
                    else                           w_next = S_WAIT_IDLE;
                end
                S_SETTLE: begin
                    if (!w_settle_done)            w_next = S_SETTLE;
                    else if (r_bit == {BIT_W{1'b0}}) w_next = S_DONE;
                    else                           w_next = S_LOAD;
                end
                S_DONE:      w_next = S_IDLE;
                S_ERROR:     w_next = w_start_edge ? S_LOAD : S_ERROR;
                default:     w_next = S_IDLE;
            endcase
        end
    end

    // Output and counter next values
    always_comb begin
        w_timer_n  = r_timer;
        w_settle_n = r_settle;
        w_bit_n    = r_bit;
        w_pbit_n   = r_pbit;
        w_ow_n     = r_ow;
        w_pupd_n   = (r_state == S_LOAD) && !abort_in;
        w_inc_n    = (r_state == S_KICK) && !abort_in;
        w_busy_n   = (w_next != S_IDLE) && (w_next != S_DONE) && (w_next != S_ERROR);
        w_done_n   = (w_next == S_DONE);
        w_err_n    = (w_next == S_ERROR);
        if (abort_in) begin
            w_bit_n = {BIT_W{1'b0}};
            w_ow_n  = 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_ERROR: begin
                    if (w_start_edge) begin
                        w_bit_n = BIT_TOP;
                        w_ow_n  = 1'b1;
                    end else begin
                        w_bit_n = r_bit;
                    end
                end
                S_LOAD:      w_pbit_n  = r_bit;
                S_KICK:      w_timer_n = {TMR_W{1'b0}};
                S_WAIT_BUSY: w_timer_n = (r_timer == TMR_MAX) ? r_timer : r_timer + 1'b1;
                S_WAIT_IDLE: begin
                    if (w_next == S_SETTLE) begin
                        w_ow_n     = 1'b0;
                        w_timer_n  = {TMR_W{1'b0}};
                        w_settle_n = {SET_W{1'b0}};
                    end else begin
                        w_timer_n = (r_timer == TMR_MAX) ? r_timer : r_timer + 1'b1;
                    end
                end
                S_SETTLE: begin
                    w_settle_n = (r_settle == SET_MAX) ? r_settle : r_settle + 1'b1;
                    if (w_settle_done && (r_bit != {BIT_W{1'b0}})) begin
                        w_bit_n = r_bit - 1'b1;
                    end else begin
                        w_bit_n = r_bit;
                    end
                end
                default: w_bit_n = r_bit;
            endcase
        end
    end

    // Registered outputs, counters and start edge history
    always_ff @(posedge clk_pixel or negedge rst_n) begin
        if (!rst_n) begin
            r_start_d <= 1'b0;
            r_armed   <= 1'b0;
            r_timer   <= {TMR_W{1'b0}};
            r_settle  <= {SET_W{1'b0}};
            r_bit     <= BIT_TOP;
            r_pbit    <= {BIT_W{1'b0}};
            r_pupd    <= 1'b0;
            r_inc     <= 1'b0;
            r_ow      <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_start_d <= start_in;
            r_armed   <= 1'b1;
            r_timer   <= w_timer_n;
            r_settle  <= w_settle_n;
            r_bit     <= w_bit_n;
            r_pbit    <= w_pbit_n;
            r_pupd    <= w_pupd_n;
            r_inc     <= w_inc_n;
            r_ow      <= w_ow_n;
            r_busy    <= w_busy_n;
            r_done    <= w_done_n;
            r_err     <= w_err_n;
        end
    end

    assign pattern_bit_out      = r_pbit;
    assign pattern_update_out   = r_pupd;
    assign increment_id_out     = r_inc;
    assign should_overwrite_out = r_ow;
    assign busy_out             = r_busy;
    assign done_out             = r_done;
    assign error_out            = r_err;

endmodule

// File: tb/tb_calibration_sequencer.sv
// Self-checking bench for calibration_sequencer with a behavioural calibration FSM model.
module tb_calibration_sequencer;

    localparam int W        = 3;
    localparam int SETTLE   = 4;
    localparam int TIMEOUT  = 100;
    localparam int BUSY     = 20;
    localparam int PASS_LEN = 3 + SETTLE + BUSY;

    logic       clk_pixel = 1'b0;
    logic       rst_n = 1'b1;
    logic       start_in = 1'b0;
    logic       abort_in = 1'b0;
    logic [2:0] cal_state_in = 3'd0;
    logic [1:0] pattern_bit_out;
    logic       pattern_update_out, increment_id_out, should_overwrite_out;
    logic       busy_out, done_out, error_out;

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;

    int inc_q[$];
    int ow_inc_q[$];
    int pb_q[$];
    int ow_q[$];
    int done_n = 0;
    int wide_n = 0;
    int err_cyc = -1;
    logic err_prev = 1'b0;
    logic mon_inc_prev = 1'b0;

    int fsm_mode = 0;  // 0 normal, 1 never busy, 2 stuck busy on second kick
    int inc_seen = 0;
    int busy_left = 0;
    logic mdl_inc_prev = 1'b0;

    calibration_sequencer #(
        .LED_ADDRESS_WIDTH(W),
        .SETTLE_CYCLES(SETTLE),
        .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .clk_pixel(clk_pixel),
        .rst_n(rst_n),
        .start_in(start_in),
        .abort_in(abort_in),
        .cal_state_in(cal_state_in),
        .pattern_bit_out(pattern_bit_out),
        .pattern_update_out(pattern_update_out),
        .increment_id_out(increment_id_out),
        .should_overwrite_out(should_overwrite_out),
        .busy_out(busy_out),
        .done_out(done_out),
        .error_out(error_out)
    );

    always #5 clk_pixel = ~clk_pixel;

    always @(posedge clk_pixel) cyc++;

    // Calibration FSM model: busy for BUSY cycles after each rising increment
    always @(negedge clk_pixel) begin
        if (increment_id_out && !mdl_inc_prev) begin
            inc_seen++;
            if (fsm_mode == 1) busy_left = 0;
            else if (fsm_mode == 2 && inc_seen == 2) busy_left = 1000000;
            else busy_left = BUSY;
        end
        mdl_inc_prev = increment_id_out;
        if (busy_left > 0) begin
            cal_state_in = 3'($urandom_range(1, 7));
            busy_left--;
        end else begin
            cal_state_in = 3'd0;
        end
    end

    // Event logger
    always @(negedge clk_pixel) begin
        if (increment_id_out) begin
            inc_q.push_back(cyc);
            ow_inc_q.push_back(int'(should_overwrite_out));
            if (mon_inc_prev) wide_n++;
        end
        mon_inc_prev = increment_id_out;
        if (pattern_update_out) begin
            pb_q.push_back(int'(pattern_bit_out));
            ow_q.push_back(int'(should_overwrite_out));
        end
        if (done_out) done_n++;
        if (error_out && !err_prev) err_cyc = cyc;
        err_prev = error_out;
    end

    task automatic clear_logs();
        @(posedge clk_pixel);
        inc_q.delete(); ow_inc_q.delete(); pb_q.delete(); ow_q.delete();
        done_n = 0; wide_n = 0; err_cyc = -1; inc_seen = 0;
    endtask

    task automatic do_start();
        @(negedge clk_pixel);
        start_in = 1'b1;
        repeat ($urandom_range(1, 3)) @(negedge clk_pixel);
        start_in = 1'b0;
    endtask

    task automatic wait_end(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk_pixel);
            if (done_out || error_out) begin
                ok = 1'b1;
                break;
            end
        end
        repeat (3) @(posedge clk_pixel);
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        #21;
        n_cmp++; if (busy_out !== 1'b0) begin $display("FAIL reset_busy: got %b want 0", busy_out); n_fail++; end
        n_cmp++; if (pattern_bit_out !== 2'd0) begin $display("FAIL reset_pbit: got %0d want 0", pattern_bit_out); n_fail++; end
        n_cmp++; if (pattern_update_out !== 1'b0) begin $display("FAIL reset_pupd: got %b want 0", pattern_update_out); n_fail++; end
        n_cmp++; if (increment_id_out !== 1'b0) begin $display("FAIL reset_inc: got %b want 0", increment_id_out); n_fail++; end
        n_cmp++; if (should_overwrite_out !== 1'b0) begin $display("FAIL reset_ow: got %b want 0", should_overwrite_out); n_fail++; end
        n_cmp++; if (done_out !== 1'b0) begin $display("FAIL reset_done: got %b want 0", done_out); n_fail++; end
        n_cmp++; if (error_out !== 1'b0) begin $display("FAIL reset_err: got %b want 0", error_out); n_fail++; end
        #14 rst_n = 1'b1;
        repeat (3) @(posedge clk_pixel);
    endtask

    task automatic test_full_run();
        bit ok;
        clear_logs();
        fsm_mode = 0;
        repeat ($urandom_range(0, 5)) @(negedge clk_pixel);
        do_start();
        // a second start edge while busy must be ignored
        repeat ($urandom_range(10, 40)) @(negedge clk_pixel);
        start_in = 1'b1;
        repeat (2) @(negedge clk_pixel);
        start_in = 1'b0;
        wait_end(400, ok);
        n_cmp++; if (ok !== 1'b1) begin $display("FAIL full_end: no done/error within budget"); n_fail++; end
        n_cmp++; if (pb_q.size() != W) begin $display("FAIL full_npass: got %0d want %0d", pb_q.size(), W); n_fail++; end
        for (int k = 0; k < pb_q.size(); k++) begin
            n_cmp++; if (pb_q[k] != W - 1 - k) begin $display("FAIL full_pbit[%0d]: got %0d want %0d", k, pb_q[k], W - 1 - k); n_fail++; end
            n_cmp++; if (ow_q[k] != ((k == 0) ? 1 : 0)) begin $display("FAIL full_ow_pupd[%0d]: got %0d want %0d", k, ow_q[k], (k == 0) ? 1 : 0); n_fail++; end
        end
        n_cmp++; if (inc_q.size() != W) begin $display("FAIL full_ninc: got %0d want %0d", inc_q.size(), W); n_fail++; end
        for (int k = 0; k < ow_inc_q.size(); k++) begin
            n_cmp++; if (ow_inc_q[k] != ((k == 0) ? 1 : 0)) begin $display("FAIL full_ow_inc[%0d]: got %0d want %0d", k, ow_inc_q[k], (k == 0) ? 1 : 0); n_fail++; end
        end
        for (int k = 1; k < inc_q.size(); k++) begin
            n_cmp++; if (inc_q[k] - inc_q[k-1] != PASS_LEN) begin $display("FAIL full_period[%0d]: got %0d want %0d", k, inc_q[k] - inc_q[k-1], PASS_LEN); n_fail++; end
            n_cmp++; if (inc_q[k] - inc_q[k-1] - 1 < 24) begin $display("FAIL full_gap[%0d]: got %0d want >=24", k, inc_q[k] - inc_q[k-1] - 1); n_fail++; end
        end
        n_cmp++; if (wide_n != 0) begin $display("FAIL full_inc_width: got %0d wide pulses want 0", wide_n); n_fail++; end
        n_cmp++; if (done_n != 1) begin $display("FAIL full_done: got %0d pulses want 1", done_n); n_fail++; end
        n_cmp++; if (busy_out !== 1'b0) begin $display("FAIL full_busy_after: got %b want 0", busy_out); n_fail++; end
        n_cmp++; if (error_out !== 1'b0) begin $display("FAIL full_err: got %b want 0", error_out); n_fail++; end
        n_cmp++; if (pattern_bit_out !== 2'd0) begin $display("FAIL full_pbit_hold: got %0d want 0", pattern_bit_out); n_fail++; end
    endtask

    task automatic test_timeout();
        bit ok;
        clear_logs();
        fsm_mode = 1;
        do_start();
        wait_end(300, ok);
        n_cmp++; if (ok !== 1'b1) begin $display("FAIL to_end: no error within budget"); n_fail++; end
        n_cmp++; if (error_out !== 1'b1) begin $display("FAIL to_err: got %b want 1", error_out); n_fail++; end
        n_cmp++; if (busy_out !== 1'b0) begin $display("FAIL to_busy: got %b want 0", busy_out); n_fail++; end
        n_cmp++; if (inc_q.size() != 1) begin $display("FAIL to_ninc: got %0d want 1", inc_q.size()); n_fail++; end
        if (inc_q.size() > 0) begin
            n_cmp++; if (err_cyc - inc_q[0] != TIMEOUT) begin $display("FAIL to_delay: got %0d want %0d", err_cyc - inc_q[0], TIMEOUT); n_fail++; end
        end
        repeat ($urandom_range(5, 15)) @(posedge clk_pixel);
        n_cmp++; if (error_out !== 1'b1) begin $display("FAIL to_err_hold: got %b want 1", error_out); n_fail++; end
        clear_logs();
        fsm_mode = 0;
        do_start();
        n_cmp++; if (error_out !== 1'b0) begin $display("FAIL to_err_clear: got %b want 0", error_out); n_fail++; end
        wait_end(400, ok);
        n_cmp++; if (done_n != 1) begin $display("FAIL to_recover_done: got %0d want 1", done_n); n_fail++; end
        n_cmp++; if (pb_q.size() != W) begin $display("FAIL to_recover_npass: got %0d want %0d", pb_q.size(), W); n_fail++; end
    endtask

    task automatic test_stuck_busy();
        bit ok;
        clear_logs();
        fsm_mode = 2;
        do_start();
        wait_end(400, ok);
        n_cmp++; if (error_out !== 1'b1) begin $display("FAIL stuck_err: got %b want 1", error_out); n_fail++; end
        n_cmp++; if (inc_q.size() != 2) begin $display("FAIL stuck_ninc: got %0d want 2", inc_q.size()); n_fail++; end
        if (inc_q.size() > 1) begin
            n_cmp++; if (err_cyc - inc_q[1] != TIMEOUT) begin $display("FAIL stuck_delay: got %0d want %0d", err_cyc - inc_q[1], TIMEOUT); n_fail++; end
        end
        repeat (50) @(posedge clk_pixel);
        n_cmp++; if (inc_q.size() != 2) begin $display("FAIL stuck_no_more_inc: got %0d want 2", inc_q.size()); n_fail++; end
        @(negedge clk_pixel);
        abort_in = 1'b1;
        @(negedge clk_pixel);
        abort_in = 1'b0;
        n_cmp++; if (error_out !== 1'b0) begin $display("FAIL stuck_abort_err: got %b want 0", error_out); n_fail++; end
        fsm_mode = 0;
        busy_left = 0;
        repeat (3) @(posedge clk_pixel);
    endtask

    task automatic test_abort();
        bit found;
        clear_logs();
        fsm_mode = 0;
        do_start();
        found = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk_pixel);
            if (pattern_update_out && pattern_bit_out == 2'd1) begin
                abort_in = 1'b1;
                found = 1'b1;
                break;
            end
        end
        n_cmp++; if (found !== 1'b1) begin $display("FAIL abort_find_kick: pass 2 never reached"); n_fail++; end
        @(negedge clk_pixel);
        abort_in = 1'b0;
        n_cmp++; if (increment_id_out !== 1'b0) begin $display("FAIL abort_inc: got %b want 0", increment_id_out); n_fail++; end
        n_cmp++; if (busy_out !== 1'b0) begin $display("FAIL abort_busy: got %b want 0", busy_out); n_fail++; end
        n_cmp++; if (should_overwrite_out !== 1'b0) begin $display("FAIL abort_ow: got %b want 0", should_overwrite_out); n_fail++; end
        n_cmp++; if (pattern_update_out !== 1'b0) begin $display("FAIL abort_pupd: got %b want 0", pattern_update_out); n_fail++; end
        n_cmp++; if (done_out !== 1'b0 || error_out !== 1'b0) begin $display("FAIL abort_done_err: got %b/%b want 0/0", done_out, error_out); n_fail++; end
        n_cmp++; if (pattern_bit_out !== 2'd1) begin $display("FAIL abort_pbit_hold: got %0d want 1", pattern_bit_out); n_fail++; end
        repeat (60) @(posedge clk_pixel);
        n_cmp++; if (inc_q.size() != 1) begin $display("FAIL abort_ninc: got %0d want 1", inc_q.size()); n_fail++; end
    endtask

    task automatic test_async_reset();
        bit found, ok, seen_hi;
        clear_logs();
        fsm_mode = 0;
        do_start();
        found = 1'b0;
        seen_hi = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk_pixel);
            if (should_overwrite_out) seen_hi = 1'b1;
            if (seen_hi && !should_overwrite_out) begin
                found = 1'b1;
                break;
            end
        end
        n_cmp++; if (found !== 1'b1) begin $display("FAIL areset_find_settle: settle never reached"); n_fail++; end
        #($urandom_range(1, 4));
        rst_n = 1'b0;
        start_in = 1'b1;
        #1;
        n_cmp++; if (busy_out !== 1'b0) begin $display("FAIL areset_busy: got %b want 0", busy_out); n_fail++; end
        n_cmp++; if (pattern_bit_out !== 2'd0) begin $display("FAIL areset_pbit: got %0d want 0", pattern_bit_out); n_fail++; end
        busy_left = 0;
        repeat (2) @(posedge clk_pixel);
        #3 rst_n = 1'b1;
        clear_logs();
        repeat (10) @(negedge clk_pixel);
        n_cmp++; if (pb_q.size() != 0 || busy_out !== 1'b0) begin $display("FAIL areset_no_start: got %0d updates busy=%b want 0/0", pb_q.size(), busy_out); n_fail++; end
        start_in = 1'b0;
        clear_logs();
        do_start();
        wait_end(400, ok);
        n_cmp++; if (done_n != 1) begin $display("FAIL areset_rerun_done: got %0d want 1", done_n); n_fail++; end
    endtask

    initial begin
        test_reset();
        test_full_run();
        test_timeout();
        test_stuck_busy();
        test_abort();
        test_async_reset();
        test_full_run();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
